// File: rtl/dmp_pkg.sv
// Shared Q16.16 types, FSM encoding and saturating arithmetic helpers for the
// PageRank gather/apply block.
package dmp_pkg;

    localparam int FRAC_BITS = 16;

    typedef logic [31:0] fix_t;

    typedef enum logic [1:0] {
        GATHER = 2'd0,
        APPLY  = 2'd1,
        DONE   = 2'd2
    } gather_state_t;

    // Clamp a wide unsigned value into 32 bits.
    function automatic fix_t sat32(input logic [63:0] v);
        return (v[63:32] != 32'd0) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    function automatic fix_t sat_add(input fix_t a, input logic [63:0] b);
        return sat32(64'(a) + b);
    endfunction

    // Unsigned Q16.16 multiply with a full 64-bit product, result not yet clamped.
    function automatic logic [63:0] mul_q16(input fix_t a, input fix_t b);
        return (64'(a) * 64'(b)) >> FRAC_BITS;
    endfunction

endpackage

// File: rtl/gather_merge.sv
// Per-node same-cycle reduction of all valid thread contributions; flags any
// valid contribution whose destination is outside the node table.
module gather_merge
    import dmp_pkg::*;
#(
    parameter int NUM_HW_THREADS = 8,
    parameter int NODES_IN_GRAPH = 32,
    parameter int SUM_W          = 32 + $clog2(NUM_HW_THREADS) + 1
) (
    input  logic [NUM_HW_THREADS*32-1:0]    i_stream,
    input  logic [NUM_HW_THREADS*32-1:0]    i_dest,
    input  logic [NUM_HW_THREADS-1:0]       i_valid,
    output logic [NODES_IN_GRAPH*SUM_W-1:0] o_sums,
    output logic                            o_bad_dest
);
    localparam int AW = $clog2(NODES_IN_GRAPH);

    always_comb begin
        o_sums     = '0;
        o_bad_dest = 1'b0;
        for (int t = 0; t < NUM_HW_THREADS; t++) begin
            if (i_valid[t]) begin
                if (i_dest[t*32 +: 32] < 32'(NODES_IN_GRAPH)) begin
                    o_sums[32'(i_dest[t*32 +: AW]) * SUM_W +: SUM_W] =
                        o_sums[32'(i_dest[t*32 +: AW]) * SUM_W +: SUM_W]
                        + SUM_W'(i_stream[t*32 +: 32]);
                end else begin
                    o_bad_dest = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gather_apply.sv
// PageRank gather/apply engine: accumulates per-node contributions, then on a
// completion edge recomputes every rank one node per cycle.
// Optional convergence detection is built when GATHER_CONVERGE_EN is defined.
module gather_apply
    import dmp_pkg::*;
#(
    parameter int          NUM_HW_THREADS = 8,
    parameter int          NODES_IN_GRAPH = 32,
    parameter logic [31:0] DAMPING        = 32'd55705,
    parameter logic [31:0] BASE_RANK      = 32'd307
`ifdef GATHER_CONVERGE_EN
    ,
    parameter logic [31:0] EPSILON        = 32'd16
`endif
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_HW_THREADS*32-1:0]      pagerank_stream,
    input  logic [NUM_HW_THREADS*32-1:0]      dest_update,
    input  logic [NUM_HW_THREADS-1:0]         stream_valid,
    input  logic                              DMP_operation_complete,
    output logic                              nextIteration,
    output logic [15:0]                       iteration_count,
    input  logic [$clog2(NODES_IN_GRAPH)-1:0] rank_rd_addr,
    output logic [31:0]                       rank_rd_data,
    output logic                              apply_busy,
    output logic                              protocol_error,
`ifdef GATHER_CONVERGE_EN
    output logic                              converged,
`endif
    output logic [1:0]                        o_fsm_state
);
    localparam int   AW        = $clog2(NODES_IN_GRAPH);
    localparam int   SUM_W     = 32 + $clog2(NUM_HW_THREADS) + 1;
    localparam fix_t RANK_INIT = fix_t'(65536 / NODES_IN_GRAPH);

    // Handshake: each stream_valid[t] qualifies its contribution for the one
    // cycle it is high; there is no backpressure, so contributions arriving
    // outside GATHER are lost and flagged.

    gather_state_t r_state;
    logic [AW-1:0] r_idx;
    fix_t          r_acc  [NODES_IN_GRAPH];
    fix_t          r_rank [NODES_IN_GRAPH];
    logic          r_dmp_q;
    logic          r_dmp_prev;
    logic          r_next;
    logic [15:0]   r_iter;
    logic          r_err;

    logic [NODES_IN_GRAPH*SUM_W-1:0] w_sums;
    logic                            w_bad_dest;
    logic                            w_edge;
    fix_t                            w_new_rank;
    logic                            w_conv_hit;
    logic                            w_conv_hold;

    gather_merge #(
        .NUM_HW_THREADS (NUM_HW_THREADS),
        .NODES_IN_GRAPH (NODES_IN_GRAPH),
        .SUM_W          (SUM_W)
    ) u_merge (
        .i_stream   (pagerank_stream),
        .i_dest     (dest_update),
        .i_valid    (stream_valid),
        .o_sums     (w_sums),
        .o_bad_dest (w_bad_dest)
    );

    assign w_edge     = r_dmp_q & ~r_dmp_prev;
    assign w_new_rank = sat32(64'(BASE_RANK) + mul_q16(DAMPING, r_acc[r_idx]));

`ifdef GATHER_CONVERGE_EN
    fix_t r_max_delta;
    fix_t w_delta;
    fix_t w_max_next;
    logic r_conv;

    assign w_delta     = (w_new_rank > r_rank[r_idx]) ? (w_new_rank - r_rank[r_idx])
                                                      : (r_rank[r_idx] - w_new_rank);
    assign w_max_next  = (w_delta > r_max_delta) ? w_delta : r_max_delta;
    assign w_conv_hit  = (w_max_next < EPSILON);
    assign w_conv_hold = r_conv;
    assign converged   = r_conv;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_max_delta <= '0;
            r_conv      <= 1'b0;
        end else if (r_state == GATHER && w_edge) begin
            r_max_delta <= '0;
        end else if (r_state == APPLY) begin
            r_max_delta <= w_max_next;
            if (r_idx == AW'(NODES_IN_GRAPH - 1)) r_conv <= w_conv_hit;
        end
    end
`else
    assign w_conv_hit  = 1'b0;
    assign w_conv_hold = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state    <= GATHER;
            r_idx      <= '0;
            r_dmp_q    <= 1'b0;
            r_dmp_prev <= 1'b0;
            r_next     <= 1'b0;
            r_iter     <= 16'd0;
            r_err      <= 1'b0;
            for (int n = 0; n < NODES_IN_GRAPH; n++) begin
                r_acc[n]  <= '0;
                r_rank[n] <= RANK_INIT;
            end
        end else begin
            r_dmp_q    <= DMP_operation_complete;
            r_dmp_prev <= r_dmp_q;
            r_next     <= 1'b0;
            if (w_bad_dest || (r_state != GATHER && |stream_valid)) r_err <= 1'b1;

            case (r_state)
                GATHER: begin
                    for (int n = 0; n < NODES_IN_GRAPH; n++) begin
                        r_acc[n] <= sat_add(r_acc[n], 64'(w_sums[n*SUM_W +: SUM_W]));
                    end
                    if (w_edge) begin
                        r_state <= APPLY;
                        r_idx   <= '0;
                    end
                end
                APPLY: begin
                    r_rank[r_idx] <= w_new_rank;
                    r_acc[r_idx]  <= '0;
                    r_idx         <= r_idx + AW'(1);
                    if (r_idx == AW'(NODES_IN_GRAPH - 1)) begin
                        r_state <= DONE;
                        r_next  <= ~w_conv_hit;
                        r_iter  <= r_iter + 16'd1;
                    end
                end
                DONE: begin
                    // A converged run parks here until reset.
                    if (!w_conv_hold) r_state <= GATHER;
                end
                default: r_state <= GATHER;
            endcase
        end
    end

    assign rank_rd_data    = r_rank[rank_rd_addr];
    assign nextIteration   = r_next;
    assign iteration_count = r_iter;
    assign apply_busy      = (r_state == APPLY);
    assign protocol_error  = r_err;
    assign o_fsm_state     = r_state;

endmodule

// File: tb/tb_gather_apply.sv
// Directed self-checking bench for gather_apply: reset values, same-cycle
// merging, saturation, protocol errors, level-held completion, mid-pass reset.
module tb_gather_apply;
  localparam int T = 8;
  localparam int N = 32;

  logic          clock;
  logic          reset_n;
  logic [T*32-1:0] pagerank_stream;
  logic [T*32-1:0] dest_update;
  logic [T-1:0]  stream_valid;
  logic          dmp_done;
  logic          next_iter;
  logic [15:0]   iter_cnt;
  logic [4:0]    rd_addr;
  logic [31:0]   rd_data;
  logic          apply_busy;
  logic          proto_err;
  logic [1:0]    fsm_state;

  int n_cmp;
  int n_bad;

  gather_apply dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .pagerank_stream        (pagerank_stream),
    .dest_update            (dest_update),
    .stream_valid           (stream_valid),
    .DMP_operation_complete (dmp_done),
    .nextIteration          (next_iter),
    .iteration_count        (iter_cnt),
    .rank_rd_addr           (rd_addr),
    .rank_rd_data           (rd_data),
    .apply_busy             (apply_busy),
    .protocol_error         (proto_err),
    .o_fsm_state            (fsm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task clear_streams();
    pagerank_stream = '0;
    dest_update     = '0;
    stream_valid    = '0;
  endtask

  // One-cycle contribution on thread t, presented between negedges.
  task send1(input int t, input logic [31:0] v, input logic [31:0] d);
    @(negedge clock);
    pagerank_stream[t*32 +: 32] = v;
    dest_update[t*32 +: 32]     = d;
    stream_valid[t]             = 1'b1;
    @(negedge clock);
    clear_streams();
  endtask

  task read_rank(input int a, output logic [31:0] v);
    rd_addr = a[4:0];
    #1;
    v = rd_data;
  endtask

  // Raise the completion level and wait for the pulse; lat is the number of
  // posedges after the one that first samples the level high.
  task run_pass(input bit inject, output int lat);
    lat = -1;
    @(negedge clock);
    dmp_done = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (inject && i == 5) begin
        pagerank_stream[0 +: 32] = 32'h4000;
        dest_update[0 +: 32]     = 32'd7;
        stream_valid[0]          = 1'b1;
      end
      if (inject && i == 6) clear_streams();
      if (next_iter) begin
        lat = i;
        break;
      end
    end
    n_cmp++;
    if (lat < 0) begin
      n_bad++;
      $display("FAIL pass_timeout: nextIteration never seen within 200 cycles");
    end
    @(negedge clock);
    dmp_done = 1'b0;
    @(negedge clock);
  endtask

  task test_reset();
    logic [31:0] v;
    do_reset();
    for (int a = 0; a < N; a++) begin
      read_rank(a, v);
      n_cmp++;
      if (v !== 32'h0000_0800) begin
        n_bad++;
        $display("FAIL reset_rank[%0d]: got %h want 00000800", a, v);
      end
    end
    n_cmp++;
    if (next_iter !== 1'b0) begin n_bad++; $display("FAIL reset_next: got %b want 0", next_iter); end
    n_cmp++;
    if (iter_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_iter: got %0d want 0", iter_cnt); end
    n_cmp++;
    if (proto_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", proto_err); end
    n_cmp++;
    if (apply_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", apply_busy); end
    n_cmp++;
    if (fsm_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
  endtask

  task test_same_dest();
    logic [31:0] v;
    logic [31:0] exp_v;
    int lat;
    @(negedge clock);
    pagerank_stream[0*32 +: 32] = 32'h1000;
    dest_update[0*32 +: 32]     = 32'd5;
    pagerank_stream[3*32 +: 32] = 32'h1000;
    dest_update[3*32 +: 32]     = 32'd5;
    stream_valid                = 8'b0000_1001;
    @(negedge clock);
    clear_streams();
    run_pass(1'b0, lat);
    n_cmp++;
    if (lat !== 33) begin n_bad++; $display("FAIL merge_latency: got %0d want 33", lat); end
    n_cmp++;
    if (iter_cnt !== 16'd1) begin n_bad++; $display("FAIL merge_iter: got %0d want 1", iter_cnt); end
    n_cmp++;
    if (next_iter !== 1'b0) begin n_bad++; $display("FAIL merge_pulse_width: got %b want 0", next_iter); end
    n_cmp++;
    if (proto_err !== 1'b0) begin n_bad++; $display("FAIL merge_err: got %b want 0", proto_err); end
    for (int a = 0; a < N; a++) begin
      exp_v = (a == 5) ? 32'd7270 : 32'd307;
      read_rank(a, v);
      n_cmp++;
      if (v !== exp_v) begin
        n_bad++;
        $display("FAIL merge_rank[%0d]: got %0d want %0d", a, v, exp_v);
      end
    end
  endtask

  task test_saturate();
    logic [31:0] v;
    int lat;
    send1(2, 32'hFFFF_F000, 32'd2);
    send1(6, 32'h0000_2000, 32'd2);
    run_pass(1'b0, lat);
    read_rank(2, v);
    n_cmp++;
    if (v !== 32'd3650683186) begin n_bad++; $display("FAIL sat_rank2: got %0d want 3650683186", v); end
    read_rank(5, v);
    n_cmp++;
    if (v !== 32'd307) begin n_bad++; $display("FAIL sat_rank5_cleared: got %0d want 307", v); end
    n_cmp++;
    if (iter_cnt !== 16'd2) begin n_bad++; $display("FAIL sat_iter: got %0d want 2", iter_cnt); end
  endtask

  task test_protocol_error();
    logic [31:0] v;
    int lat;
    send1(1, 32'h5000, 32'd40);
    n_cmp++;
    if (proto_err !== 1'b1) begin n_bad++; $display("FAIL err_bad_dest: got %b want 1", proto_err); end
    run_pass(1'b1, lat);
    read_rank(8, v);
    n_cmp++;
    if (v !== 32'd307) begin n_bad++; $display("FAIL err_rank8: got %0d want 307", v); end
    read_rank(7, v);
    n_cmp++;
    if (v !== 32'd307) begin n_bad++; $display("FAIL err_rank7: got %0d want 307", v); end
    n_cmp++;
    if (proto_err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", proto_err); end
    n_cmp++;
    if (iter_cnt !== 16'd3) begin n_bad++; $display("FAIL err_iter: got %0d want 3", iter_cnt); end
  endtask

  task test_held_high();
    int pulses;
    int busy_rises;
    logic busy_d;
    pulses     = 0;
    busy_rises = 0;
    busy_d     = 1'b0;
    @(negedge clock);
    dmp_done = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (next_iter) pulses++;
      if (apply_busy && !busy_d) busy_rises++;
      busy_d = apply_busy;
    end
    @(negedge clock);
    dmp_done = 1'b0;
    n_cmp++;
    if (pulses !== 1) begin n_bad++; $display("FAIL held_pulses: got %0d want 1", pulses); end
    n_cmp++;
    if (busy_rises !== 1) begin n_bad++; $display("FAIL held_passes: got %0d want 1", busy_rises); end
    n_cmp++;
    if (iter_cnt !== 16'd4) begin n_bad++; $display("FAIL held_iter: got %0d want 4", iter_cnt); end
  endtask

  task test_reset_mid_apply();
    logic [31:0] v;
    send1(0, 32'h8000, 32'd0);
    @(negedge clock);
    dmp_done = 1'b1;
    // After posedge 11 the pass sits at index 10.
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (apply_busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", apply_busy); end
    reset_n  = 1'b0;
    dmp_done = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    n_cmp++;
    if (fsm_state !== 2'd0) begin n_bad++; $display("FAIL mid_state: got %0d want 0", fsm_state); end
    n_cmp++;
    if (iter_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_iter: got %0d want 0", iter_cnt); end
    n_cmp++;
    if (proto_err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b want 0", proto_err); end
    for (int a = 0; a < N; a++) begin
      read_rank(a, v);
      n_cmp++;
      if (v !== 32'h0000_0800) begin
        n_bad++;
        $display("FAIL mid_rank[%0d]: got %h want 00000800", a, v);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    reset_n  = 1'b0;
    dmp_done = 1'b0;
    rd_addr  = '0;
    clear_streams();
    test_reset();
    test_same_dest();
    test_saturate();
    test_protocol_error();
    test_held_high();
    test_reset_mid_apply();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
